// File: rtl/rv32m_muldiv_unit.sv
// rv32m_muldiv_unit: iterative RV32M multiply/divide, 32-step shift-add / restoring divide
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic            iKill,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic            oStall,
  output logic [XLEN-1:0] oResult
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [2:0] f3;
  logic negX, negR;
  logic [63:0] acc;
  logic [32:0] rem;
  logic [31:0] opB;
  logic sgnA, sgnB, accept, fast;
  logic [31:0] magA, magB, qRes, rRes, res;
  logic [63:0] prod;
  logic [32:0] sum, sh, trial;
  assign oBusy = state != IDLE;
  assign oStall = iStart & ~oDone;
  always_comb begin
    sgnA = iA[31] & (iFunct3 == 3'b001 | iFunct3 == 3'b010 | iFunct3 == 3'b100 | iFunct3 == 3'b110);
    sgnB = iB[31] & (iFunct3 == 3'b001 | iFunct3 == 3'b100 | iFunct3 == 3'b110);
    magA = sgnA ? -iA : iA;
    magB = sgnB ? -iB : iB;
    accept = state == IDLE & iStart & ~iKill & ~oDone;
    fast = iFunct3[2] & (iB == 32'd0 | (~iFunct3[0] & iA == 32'h8000_0000 & iB == 32'hFFFF_FFFF));
    sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opB : 32'd0};
    sh = {rem[31:0], acc[31]};
    trial = sh - {1'b0, opB};
    prod = negX ? -acc : acc;
    qRes = negX ? -acc[31:0] : acc[31:0];
    rRes = negR ? -rem[31:0] : rem[31:0];
    res = f3[2] ? (f3[1] ? rRes : qRes) : (f3[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      negX <= 1'b0;
      negR <= 1'b0;
      acc <= '0;
      rem <= '0;
      opB <= '0;
      oDone <= 1'b0;
      oResult <= '0;
    end else if (iKill) begin
      state <= IDLE;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          f3 <= iFunct3;
          cnt <= '0;
          if (fast) begin
            // special cases bypass the sign fix-up: results are already final
            state <= FIX;
            negX <= 1'b0;
            negR <= 1'b0;
            acc <= {32'd0, iB == 32'd0 ? 32'hFFFF_FFFF : 32'h8000_0000};
            rem <= {1'b0, iB == 32'd0 ? iA : 32'd0};
          end else begin
            state <= CALC;
            negX <= sgnA ^ sgnB;
            negR <= sgnA;
            acc <= {32'd0, iFunct3[2] ? magA : magB};
            rem <= '0;
            opB <= iFunct3[2] ? magB : magA;
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (f3[2]) begin
            rem <= trial[32] ? sh : trial;
            acc[31:0] <= {acc[30:0], ~trial[32]};
          end else begin
            acc <= {sum, acc[31:1]};
          end
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          oResult <= res;
          oDone <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// tb_rv32m_muldiv_unit: vector table, abort/reset sequences and randomized ops vs arithmetic model
module tb_rv32m_muldiv_unit;
  logic iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0, iKill = 1'b0;
  logic [2:0] iFunct3 = '0;
  logic [31:0] iA = '0, iB = '0;
  logic oBusy, oDone, oStall;
  logic [31:0] oResult;
  int errors = 0, checks = 0;

  rv32m_muldiv_unit #(.XLEN(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iKill(iKill), .iFunct3(iFunct3),
    .iA(iA), .iB(iB), .oBusy(oBusy), .oDone(oDone), .oStall(oStall), .oResult(oResult)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic isFast;
    string name;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic ovf;
    ea = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p = ea * eb;
    sa = a;
    sb = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // request held through completion and one edge beyond; operands scrambled after acceptance
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic isFast, input string name);
    int n = 0, busy = 0;
    logic done = 1'b0;
    @(negedge iCLK);
    iFunct3 = f; iA = a; iB = b; iStart = 1'b1;
    while (n < 60 && !done) begin
      @(posedge iCLK);
      n++;
      #1 iA = $urandom; iB = $urandom;
      @(negedge iCLK);
      if (oDone) done = 1'b1;
      else busy += int'(oBusy);
    end
    chk({name, " latency"}, 64'(n), isFast ? 64'd2 : 64'd34);
    chk({name, " result"}, {32'd0, oResult}, {32'd0, exp});
    chk({name, " busy"}, 64'(busy), isFast ? 64'd1 : 64'd33);
    chk({name, " stall"}, {63'd0, oStall}, 64'd0);
    @(posedge iCLK);
    @(negedge iCLK);
    chk({name, " held"}, {62'd0, oBusy, oDone}, 64'd0);
    iStart = 1'b0;
  endtask

  vec_t vecs[12];
  int pulses;

  initial begin
    vecs[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul"};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh"};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu"};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu"};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div"};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem"};
    vecs[6]  = '{3'd5, 32'd100, 32'd7, 32'h0000_000E, 1'b0, "divu"};
    vecs[7]  = '{3'd7, 32'd100, 32'd7, 32'h0000_0002, 1'b0, "remu"};
    vecs[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "div0"};
    vecs[9]  = '{3'd7, 32'd5, 32'd0, 32'd5, 1'b1, "remu0"};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "divovf"};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "removf"};

    iStart = 1'b1;
    #12;
    chk("reset result", {32'd0, oResult}, 64'd0);
    chk("reset flags", {61'd0, oBusy, oDone, oStall}, 64'd1);
    @(negedge iCLK);
    iStart = 1'b0;
    iRST = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].isFast, vecs[i].name);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "prekill");
    @(negedge iCLK);
    iFunct3 = 3'd3; iA = 32'h1234_5678; iB = 32'h9ABC_DEF0; iStart = 1'b1;
    @(posedge iCLK);
    repeat (10) @(posedge iCLK);
    @(negedge iCLK);
    iKill = 1'b1; iStart = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    iKill = 1'b0;
    chk("kill flags", {62'd0, oBusy, oDone}, 64'd0);
    chk("kill result", {32'd0, oResult}, 64'hFFFF_FFEB);
    pulses = 0;
    repeat (40) begin
      @(negedge iCLK);
      pulses += int'(oDone);
    end
    chk("kill nodone", 64'(pulses), 64'd0);
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 1'b0, "postkill");

    @(negedge iCLK);
    iFunct3 = 3'd4; iA = 32'd1000; iB = 32'd7; iStart = 1'b1;
    @(posedge iCLK);
    repeat (20) @(posedge iCLK);
    #2 iRST = 1'b1;
    #1;
    chk("rst result", {32'd0, oResult}, 64'd0);
    chk("rst flags", {62'd0, oBusy, oDone}, 64'd0);
    @(negedge iCLK);
    iStart = 1'b0;
    iRST = 1'b0;

    for (int k = 0; k < 40; k++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(f, a, b, model(f, a, b), is_fast(f, a, b), $sformatf("rand%0d f%0d", k, f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
